// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch-prediction path (FSM state, in-flight entry,
// outcome encoding used by both the 2-bit predictor and the resolve tracker).
package bp_pkg;

  localparam int BP_PC_W = 32;

  // Outcome encoding shared with the predictor's result input
  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  typedef logic [0:0] bp_state_t;
  localparam bp_state_t RUN   = 1'b0;
  localparam bp_state_t FLUSH = 1'b1;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
  } bp_entry_t;

  // Mispredict test in terms of the shared outcome encoding
  function automatic logic bp_is_miss(input logic pred_taken, input logic actual_taken);
    logic miss;
    if ((pred_taken == TAKEN) && (actual_taken == NOT_TAKEN)) begin
      miss = 1'b1;
    end else if ((pred_taken == NOT_TAKEN) && (actual_taken == TAKEN)) begin
      miss = 1'b1;
    end else begin
      miss = 1'b0;
    end
    return miss;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: DEPTH-entry circular buffer of in-flight predictions with a
// synchronous clear that takes priority over push/pop.
module bp_inflight_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [W-1:0]  mem_r [DEPTH];
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (clr) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents behind the pointers are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/bp_resolve_tracker.sv
// bp_resolve_tracker: in-order tracker of in-flight branch predictions; emits predictor
// updates, mispredict pulses, wrong-path flush and statistics. Option: BP_PC_CHECK_EN.
module bp_resolve_tracker
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic                   pred_taken,
  input  logic [PC_W-1:0]        pred_pc,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic                   res_taken,
  input  logic [PC_W-1:0]        res_pc,
  output logic                   upd_valid,
  output logic                   upd_taken,
  output logic [PC_W-1:0]        upd_pc,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic                   pc_err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bp_state_t        state_r;
  bp_state_t        state_nxt_s;
  logic             run_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_fire_s;
  logic             res_fire_s;
  logic             miss_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_clr_s;
  logic [PC_W:0]    wr_data_s;
  logic [PC_W:0]    head_data_s;
  logic [PC_W-1:0]  head_pc_s;
  logic             head_taken_s;
  logic [OCC_W-1:0] occ_s;

  logic             upd_valid_r;
  logic             upd_taken_r;
  logic [PC_W-1:0]  upd_pc_r;
  logic             mispredict_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  assign run_s        = (state_r == RUN);
  assign pred_ready   = !fifo_full_s && run_s;
  assign res_ready    = !fifo_empty_s && run_s;
  assign push_fire_s  = pred_valid && pred_ready;
  assign res_fire_s   = res_valid && res_ready;
  assign head_pc_s    = head_data_s[PC_W:1];
  assign head_taken_s = head_data_s[0];
  assign miss_s       = res_fire_s && bp_is_miss(head_taken_s, res_taken);

  // A mispredicting resolve drops any same-cycle push and empties the buffer at once
  assign fifo_push_s = push_fire_s && !miss_s;
  assign fifo_pop_s  = res_fire_s && !miss_s;
  assign fifo_clr_s  = miss_s || (state_r == FLUSH);
  assign wr_data_s   = {pred_pc, pred_taken};

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fifo_clr_s),
    .push      (fifo_push_s),
    .push_data (wr_data_s),
    .pop       (fifo_pop_s),
    .head_data (head_data_s),
    .count     (occ_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // RUN/FLUSH sequencing: FLUSH lasts exactly one cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (miss_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH:   state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered update towards the predictor; upd_taken/upd_pc hold between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_r  <= 1'b0;
      upd_taken_r  <= 1'b0;
      upd_pc_r     <= '0;
      mispredict_r <= 1'b0;
    end else begin
      upd_valid_r  <= res_fire_s;
      mispredict_r <= miss_s;
      if (res_fire_s) begin
        upd_taken_r <= res_taken;
        upd_pc_r    <= head_pc_s;
      end
    end
  end

  // Saturating accuracy statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_r <= '0;
      miss_cnt_r   <= '0;
    end else begin
      if (res_fire_s && (branch_cnt_r != CNT_MAX)) begin
        branch_cnt_r <= branch_cnt_r + CNT_W'(1);
      end
      if (miss_s && (miss_cnt_r != CNT_MAX)) begin
        miss_cnt_r <= miss_cnt_r + CNT_W'(1);
      end
    end
  end

`ifdef BP_PC_CHECK_EN
  logic pc_err_r;

  // Sticky mismatch between the resolving PC and the tracked head PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_err_r <= 1'b0;
    end else if (res_fire_s && (res_pc != head_pc_s)) begin
      pc_err_r <= 1'b1;
    end
  end

  assign pc_err = pc_err_r;
`else
  logic unused_res_pc_s;
  assign unused_res_pc_s = ^res_pc;
  assign pc_err          = 1'b0;
`endif

  assign upd_valid  = upd_valid_r;
  assign upd_taken  = upd_taken_r;
  assign upd_pc     = upd_pc_r;
  assign mispredict = mispredict_r;
  assign occupancy  = occ_s;
  assign branch_cnt = branch_cnt_r;
  assign miss_cnt   = miss_cnt_r;

endmodule
